// File: rtl/ftb_update_sched.sv
// Arbitrates FTQ training updates (read tag, select way, write) against BPU
// prediction lookups on the single-port FTB SRAM, bounding update starvation.
module ftb_update_sched #(
    parameter int FTB_SETS     = 512,
    parameter int FTB_WAYS     = 4,
    parameter int IDX_LSB      = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int ENTRY_W      = 64,
    parameter int XLEN         = 64,
    localparam int IDX_W       = $clog2(FTB_SETS),
    localparam int WAY_W       = $clog2(FTB_WAYS),
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_update_req,
    input  logic [XLEN-1:0]     i_update_addr,
    input  logic [ENTRY_W-1:0]  i_update_entry,
    output logic                o_update_finished,
    input  logic                i_lookup_req,
    input  logic [XLEN-1:0]     i_lookup_addr,
    output logic                o_lookup_gnt,
    output logic                o_sram_en,
    output logic                o_sram_we,
    output logic [IDX_W-1:0]    o_sram_set,
    output logic [FTB_WAYS-1:0] o_sram_way_mask,
    output logic [ENTRY_W-1:0]  o_sram_wdata,
    input  logic [FTB_WAYS-1:0] i_sram_hit_vec
);

    typedef enum logic [1:0] {IDLE, RESP, WR} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [WAY_W-1:0]   hit_idx;
    logic               upd_win, upd_rd, upd_wr, upd_acc, starve_max;
    logic [IDX_W-1:0]   upd_idx, lk_idx;
    logic [FTB_WAYS-1:0] way_oh;
    logic               unused_addr_bits;

    assign upd_idx    = i_update_addr[IDX_LSB +: IDX_W];
    assign lk_idx     = i_lookup_addr[IDX_LSB +: IDX_W];
    assign starve_max = (starve_q == CNT_W'(STARVE_LIMIT));
    assign upd_win    = !i_lookup_req || starve_max;
    assign upd_acc    = upd_rd || upd_wr;
    assign way_oh     = {{(FTB_WAYS-1){1'b0}}, 1'b1} << way_q;
    assign unused_addr_bits = ^{i_update_addr, i_lookup_addr};

    // Lowest-index hit wins; multiple hits are flagged by the assertion below.
    always_comb begin
        hit_idx = '0;
        for (int i = FTB_WAYS - 1; i >= 0; i--)
            if (i_sram_hit_vec[i]) hit_idx = WAY_W'(i);
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        victim_d = victim_q;
        way_d    = way_q;
        upd_rd   = 1'b0;
        upd_wr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_update_req) begin
                    starve_d = '0;
                end else if (upd_win) begin
                    upd_rd   = 1'b1;
                    starve_d = '0;
                    state_d  = RESP;
                end else begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (!i_update_req) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR;
                    if (|i_sram_hit_vec) begin
                        way_d = hit_idx;
                    end else begin
                        way_d    = victim_q;
                        victim_d = victim_q + WAY_W'(1);
                    end
                end
            end
            WR: begin
                if (!i_update_req) begin
                    // FTQ squash: abandon without writing or acknowledging
                    starve_d = '0;
                    state_d  = IDLE;
                end else if (upd_win) begin
                    upd_wr   = 1'b1;
                    starve_d = '0;
                    state_d  = IDLE;
                end else begin
                    starve_d = starve_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
            victim_q <= '0;
            way_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            victim_q <= victim_d;
            way_q    <= way_d;
        end
    end

    // Outputs are forced low while reset is asserted, even mid-cycle.
    always_comb begin
        o_sram_en         = 1'b0;
        o_sram_we         = 1'b0;
        o_sram_set        = '0;
        o_sram_way_mask   = '0;
        o_sram_wdata      = '0;
        o_lookup_gnt      = 1'b0;
        o_update_finished = 1'b0;
        if (rst) begin
            if (upd_acc) begin
                o_sram_en  = 1'b1;
                o_sram_we  = upd_wr;
                o_sram_set = upd_idx;
                if (upd_wr) begin
                    o_sram_way_mask   = way_oh;
                    o_sram_wdata      = i_update_entry;
                    o_update_finished = 1'b1;
                end
            end else if (i_lookup_req) begin
                o_sram_en    = 1'b1;
                o_sram_set   = lk_idx;
                o_lookup_gnt = 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst && state_q == RESP && i_update_req)
            assert ($countones(i_sram_hit_vec) <= 1)
            else $error("ftb_update_sched: multiple FTB way hits %b", i_sram_hit_vec);
    end
`endif

endmodule
